// File: rtl/uart_pkt_decoder.sv
// uart_pkt_decoder
//   Receive-side packet layer above uart_rx. Parses framed packets
//   [SYNC][CMD][LEN][PAYLOAD x LEN][CSUM] from the RX byte stream, buffers the
//   payload and releases it as a valid/ready stream only once the checksum has
//   matched. Error conditions are reported as single-cycle pulses, at most one
//   per cycle.
//
//   Build option: define PKT_CRC8_EN to use CRC-8 (poly 0x07, init 0x00, no
//   reflection, no xorout) as the packet checksum instead of the 8-bit XOR.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   i_rx_data[7:0]    byte from uart_rx
//   i_rx_valid        one-cycle byte strobe (cannot be back-pressured)
//   i_rx_err          framing/parity error qualifying i_rx_valid
//   o_cmd[7:0]        CMD of the packet being drained
//   o_len[7:0]        LEN of the packet being drained
//   o_data[7:0]       payload beat
//   o_valid, i_ready  payload handshake
//   o_last            final payload beat
//   o_err_csum        checksum mismatch pulse
//   o_err_len         LEN==0 or LEN>MAX_LEN pulse
//   o_err_tmo         inter-byte timeout pulse
//   o_err_line        byte received with i_rx_err pulse
//   o_err_drop        byte discarded while draining pulse
//   o_pkt_cnt[15:0]   good-packet counter, wraps
//   o_busy            decoder not idle
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | hunting for SYNC_BYTE
// S_CMD     | waiting for the command byte
// S_LEN     | waiting for the length byte
// S_PAYLOAD | storing payload bytes into the buffer
// S_CSUM    | waiting for the checksum byte
// S_DRAIN   | presenting the buffered payload downstream
module uart_pkt_decoder #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 64,
  parameter int         TIMEOUT_CYC = 65536
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_err,
  output logic [7:0]  o_cmd,
  output logic [7:0]  o_len,
  output logic [7:0]  o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_last,
  output logic        o_err_csum,
  output logic        o_err_len,
  output logic        o_err_tmo,
  output logic        o_err_line,
  output logic        o_err_drop,
  output logic [15:0] o_pkt_cnt,
  output logic        o_busy
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC - 1) : 1;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  // The counter holds (idle clocks since the last byte) - 1, so the expiry
  // decision is taken on the edge TIMEOUT_CYC-1 clocks after the last strobe.
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN
  } state_t;

  state_t          r_state, w_next;
  logic [7:0]      r_cmd, r_len, r_sum, r_wr_idx, r_rd_idx;
  logic [15:0]     r_pkt_cnt;
  logic [TW-1:0]   r_tmo_cnt;
  logic [7:0]      r_buf [MAX_LEN];
  logic            r_err_csum, r_err_len, r_err_tmo, r_err_line, r_err_drop;

  logic            w_byte, w_line, w_tmo_exp, w_counting, w_hs, w_len_bad;
  logic            w_err_csum, w_err_len, w_err_tmo, w_err_line, w_err_drop;
  logic [7:0]      w_sum_nxt;

  function automatic logic [7:0] f_sum(input logic [7:0] s, input logic [7:0] b);
    logic [7:0] c;
`ifdef PKT_CRC8_EN
    c = s ^ b;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
`else
    c = s ^ b;
`endif
    return c;
  endfunction

  assign w_byte     = i_rx_valid && !i_rx_err;
  assign w_line     = i_rx_valid && i_rx_err;
  assign w_counting = (r_state == S_CMD) || (r_state == S_LEN) ||
                      (r_state == S_PAYLOAD) || (r_state == S_CSUM);
  // A byte arriving on the expiry cycle takes precedence over the timeout.
  assign w_tmo_exp  = (r_tmo_cnt == TMO_LAST) && !i_rx_valid;
  assign w_hs       = (r_state == S_DRAIN) && i_ready;
  assign w_len_bad  = (i_rx_data == 8'h00) || (i_rx_data > MAX_LEN_B);
  // CMD is the first byte covered by the checksum, so it restarts from zero.
  assign w_sum_nxt  = f_sum((r_state == S_CMD) ? 8'h00 : r_sum, i_rx_data);

  always_comb begin
    w_next     = r_state;
    w_err_csum = 1'b0;
    w_err_len  = 1'b0;
    w_err_tmo  = 1'b0;
    w_err_line = 1'b0;
    w_err_drop = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_line)                                   w_err_line = 1'b1;
        else if (w_byte && (i_rx_data == SYNC_BYTE))  w_next = S_CMD;
      end
      S_CMD, S_LEN, S_PAYLOAD, S_CSUM: begin
        if (w_line) begin
          w_err_line = 1'b1;
          w_next     = S_IDLE;
        end else if (w_byte) begin
          case (r_state)
            S_CMD: w_next = S_LEN;
            S_LEN: begin
              if (w_len_bad) begin
                w_err_len = 1'b1;
                w_next    = S_IDLE;
              end else begin
                w_next = S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              if (r_wr_idx == r_len - 8'd1) w_next = S_CSUM;
            end
            default: begin
              if (i_rx_data == r_sum) begin
                w_next = S_DRAIN;
              end else begin
                w_err_csum = 1'b1;
                w_next     = S_IDLE;
              end
            end
          endcase
        end else if (w_tmo_exp) begin
          w_err_tmo = 1'b1;
          w_next    = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (i_rx_valid)                         w_err_drop = 1'b1;
        if (w_hs && (r_rd_idx == r_len - 8'd1)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cmd      <= 8'h00;
      r_len      <= 8'h00;
      r_sum      <= 8'h00;
      r_wr_idx   <= 8'h00;
      r_rd_idx   <= 8'h00;
      r_pkt_cnt  <= 16'h0000;
      r_tmo_cnt  <= '0;
      r_err_csum <= 1'b0;
      r_err_len  <= 1'b0;
      r_err_tmo  <= 1'b0;
      r_err_line <= 1'b0;
      r_err_drop <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_err_csum <= w_err_csum;
      r_err_len  <= w_err_len;
      r_err_tmo  <= w_err_tmo;
      r_err_line <= w_err_line;
      r_err_drop <= w_err_drop;

      if (i_rx_valid || !w_counting) r_tmo_cnt <= '0;
      else                           r_tmo_cnt <= r_tmo_cnt + TW'(1);

      if (w_byte) begin
        case (r_state)
          S_CMD: begin
            r_cmd <= i_rx_data;
            r_sum <= w_sum_nxt;
          end
          S_LEN: begin
            if (!w_len_bad) begin
              r_len    <= i_rx_data;
              r_wr_idx <= 8'h00;
              r_sum    <= w_sum_nxt;
            end
          end
          S_PAYLOAD: begin
            r_wr_idx <= r_wr_idx + 8'd1;
            r_sum    <= w_sum_nxt;
          end
          S_CSUM: begin
            if (i_rx_data == r_sum) begin
              r_pkt_cnt <= r_pkt_cnt + 16'd1;
              r_rd_idx  <= 8'h00;
            end
          end
          default: ;
        endcase
      end

      if (w_hs) r_rd_idx <= r_rd_idx + 8'd1;
    end
  end

  // Payload storage needs no reset; every slot read in DRAIN was written first.
  always_ff @(posedge clk) begin
    if ((r_state == S_PAYLOAD) && w_byte) r_buf[r_wr_idx[IW-1:0]] <= i_rx_data;
  end

  assign o_valid    = (r_state == S_DRAIN);
  assign o_data     = o_valid ? r_buf[r_rd_idx[IW-1:0]] : 8'h00;
  assign o_last     = o_valid && (r_rd_idx == r_len - 8'd1);
  assign o_cmd      = r_cmd;
  assign o_len      = r_len;
  assign o_pkt_cnt  = r_pkt_cnt;
  assign o_busy     = (r_state != S_IDLE);
  assign o_err_csum = r_err_csum;
  assign o_err_len  = r_err_len;
  assign o_err_tmo  = r_err_tmo;
  assign o_err_line = r_err_line;
  assign o_err_drop = r_err_drop;

endmodule

// File: tb/tb_uart_pkt_decoder.sv
module tb_uart_pkt_decoder;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_rx_err = 1'b0;
  logic        i_ready = 1'b1;
  logic [7:0]  o_cmd, o_len, o_data;
  logic        o_valid, o_last, o_busy;
  logic        o_err_csum, o_err_len, o_err_tmo, o_err_line, o_err_drop;
  logic [15:0] o_pkt_cnt;

  uart_pkt_decoder #(.SYNC_BYTE(8'hA5), .MAX_LEN(64), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .i_rx_err(i_rx_err),
    .o_cmd(o_cmd), .o_len(o_len), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_last(o_last),
    .o_err_csum(o_err_csum), .o_err_len(o_err_len), .o_err_tmo(o_err_tmo),
    .o_err_line(o_err_line), .o_err_drop(o_err_drop),
    .o_pkt_cnt(o_pkt_cnt), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Passive monitor: event counters sampled on the falling edge.
  int cyc = 0;
  int n_csum = 0, n_len = 0, n_tmo = 0, n_line = 0, n_drop = 0;
  int tmo_cyc = 0, multi_err = 0, stall_viol = 0;
  logic [7:0] beats [$];
  logic       lasts [$];
  logic       p_stall = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       p_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int e;
    e = 0;
    if (o_err_csum) begin n_csum++; e++; end
    if (o_err_len)  begin n_len++;  e++; end
    if (o_err_tmo)  begin n_tmo++;  e++; tmo_cyc = cyc; end
    if (o_err_line) begin n_line++; e++; end
    if (o_err_drop) begin n_drop++; e++; end
    if (e > 1) multi_err++;
    if (o_valid && i_ready) begin
      beats.push_back(o_data);
      lasts.push_back(o_last);
    end
    if (p_stall && ((o_valid !== 1'b1) || (o_data !== p_data) || (o_last !== p_last)))
      stall_viol++;
    p_stall = o_valid && !i_ready;
    p_data  = o_data;
    p_last  = o_last;
  end

  logic [7:0] pl [$];

  function automatic logic [7:0] sum_step(input logic [7:0] s, input logic [7:0] b);
    logic [7:0] c;
    c = s ^ b;
`ifdef PKT_CRC8_EN
    for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
`endif
    return c;
  endfunction

  function automatic logic [7:0] calc_csum(input logic [7:0] cmd, input logic [7:0] len);
    logic [7:0] s;
    s = sum_step(8'h00, cmd);
    s = sum_step(s, len);
    foreach (pl[i]) s = sum_step(s, pl[i]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    i_rx_err   = e;
    tick();
    i_rx_valid = 1'b0;
    i_rx_err   = 1'b0;
    i_rx_data  = 8'h00;
  endtask

  task automatic send_pkt(input logic [7:0] cmd, input logic [7:0] len, input logic bad);
    logic [7:0] cs;
    cs = calc_csum(cmd, len) ^ (bad ? 8'h07 : 8'h00);
    send_byte(8'hA5, 1'b0);
    send_byte(cmd, 1'b0);
    send_byte(len, 1'b0);
    foreach (pl[i]) send_byte(pl[i], 1'b0);
    send_byte(cs, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (o_busy && (k < budget)) begin
      tick();
      k++;
    end
    chk("wait_idle", 32'(o_busy), 32'h0);
  endtask

  task automatic chk_beats(input string tag, input int base);
    chk({tag, "_count"}, beats.size() - base, pl.size());
    for (int i = 0; i < pl.size(); i++) begin
      if (base + i < beats.size()) begin
        chk({tag, "_data"}, 32'(beats[base + i]), 32'(pl[i]));
        chk({tag, "_last"}, 32'(lasts[base + i]), 32'(i == pl.size() - 1));
      end
    end
  endtask

  initial begin
    int b0, s0, s1, st;

    // Reset
    gap(3);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_busy",  32'(o_busy), 0);
    chk("rst_cnt",   32'(o_pkt_cnt), 0);
    chk("rst_cmd",   32'(o_cmd), 0);
    chk("rst_len",   32'(o_len), 0);
    chk("rst_data",  32'(o_data), 0);
    chk("rst_errs",  32'({o_err_csum, o_err_len, o_err_tmo, o_err_line, o_err_drop, o_last}), 0);
    rst_n = 1'b1;
    tick();

    // 1: good packet
    pl = '{8'h11, 8'h22, 8'h33};
    b0 = beats.size(); s0 = n_csum;
    send_pkt(8'h10, 8'h03, 1'b0);
    chk("t1_lat_valid", 32'(o_valid), 1);
    chk("t1_first",     32'(o_data), 32'h11);
    chk("t1_cmd",       32'(o_cmd), 32'h10);
    chk("t1_len",       32'(o_len), 32'h03);
    chk("t1_cnt",       32'(o_pkt_cnt), 1);
    wait_idle(20);
    chk_beats("t1", b0);
    chk("t1_no_csum_err", n_csum - s0, 0);

    // 2: bad checksum then recovery
    b0 = beats.size(); s0 = n_csum;
    send_pkt(8'h10, 8'h03, 1'b1);
    chk("t2_no_valid", 32'(o_valid), 0);
    gap(3);
    chk("t2_csum_err", n_csum - s0, 1);
    chk("t2_no_beats", beats.size() - b0, 0);
    chk("t2_cnt",      32'(o_pkt_cnt), 1);
    send_pkt(8'h10, 8'h03, 1'b0);
    wait_idle(20);
    chk_beats("t2_retry", b0);
    chk("t2_cnt2", 32'(o_pkt_cnt), 2);

    // 3: length errors, MAX_LEN boundary, leading junk
    s0 = n_len;
    send_byte(8'hA5, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h00, 1'b0);
    gap(2);
    chk("t3_len0",      n_len - s0, 1);
    chk("t3_len0_busy", 32'(o_busy), 0);
    send_byte(8'hA5, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h41, 1'b0);
    gap(2);
    chk("t3_len65", n_len - s0, 2);
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'(i));
    b0 = beats.size();
    send_pkt(8'h10, 8'h40, 1'b0);
    wait_idle(100);
    chk_beats("t3_len64", b0);
    chk("t3_cnt", 32'(o_pkt_cnt), 3);
    chk("t3_len64_noerr", n_len - s0, 2);
    pl = '{8'h7E};
    b0 = beats.size();
    send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0);
    send_pkt(8'h01, 8'h01, 1'b0);
    wait_idle(20);
    chk_beats("t3_junk", b0);
    chk("t3_cnt2", 32'(o_pkt_cnt), 4);

    // 4: timeout exactly TMO-1 clocks after last strobe; byte on expiry wins
    s0 = n_tmo;
    send_byte(8'hA5, 1'b0); send_byte(8'h10, 1'b0);
    st = cyc;
    gap(TMO + 5);
    chk("t4_tmo",      n_tmo - s0, 1);
    chk("t4_tmo_time", tmo_cyc - st, TMO - 1);
    chk("t4_tmo_busy", 32'(o_busy), 0);
    pl = '{8'h5A};
    b0 = beats.size();
    send_byte(8'hA5, 1'b0); send_byte(8'h10, 1'b0);
    gap(TMO - 2);
    send_byte(8'h01, 1'b0);
    gap(2);
    chk("t4_byte_wins", n_tmo - s0, 1);
    chk("t4_still_busy", 32'(o_busy), 1);
    send_byte(8'h5A, 1'b0);
    send_byte(calc_csum(8'h10, 8'h01), 1'b0);
    wait_idle(20);
    chk_beats("t4", b0);
    chk("t4_cnt", 32'(o_pkt_cnt), 5);

    // 5: backpressure with a byte injected during drain
    i_ready = 1'b0;
    pl = '{8'h11, 8'h22, 8'h33};
    b0 = beats.size(); s0 = n_drop;
    send_pkt(8'h10, 8'h03, 1'b0);
    gap(50);
    send_byte(8'h5A, 1'b0);
    gap(49);
    chk("t5_valid",  32'(o_valid), 1);
    chk("t5_data",   32'(o_data), 32'h11);
    chk("t5_last",   32'(o_last), 0);
    chk("t5_drop",   n_drop - s0, 1);
    chk("t5_nobeat", beats.size() - b0, 0);
    i_ready = 1'b1;
    wait_idle(20);
    chk_beats("t5", b0);
    chk("t5_cnt", 32'(o_pkt_cnt), 6);

    // 6: line error mid-payload and in IDLE; CRC/XOR discriminating packet
    s0 = n_line; b0 = beats.size();
    send_byte(8'hA5, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b1);
    chk("t6_line_idle", 32'(o_busy), 0);
    gap(2);
    chk("t6_line",    n_line - s0, 1);
    chk("t6_nobeats", beats.size() - b0, 0);
    send_byte(8'hA5, 1'b1);
    gap(2);
    chk("t6_line_in_idle", n_line - s0, 2);
    chk("t6_err_sync_ignored", 32'(o_busy), 0);
    s1 = n_csum;
    pl = '{8'h00};
    b0 = beats.size();
    send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0); send_byte(8'h15, 1'b0);
    wait_idle(20);
    gap(2);
`ifdef PKT_CRC8_EN
    chk_beats("t6_crc", b0);
    chk("t6_crc_cnt",   32'(o_pkt_cnt), 7);
    chk("t6_crc_noerr", n_csum - s1, 0);
`else
    chk("t6_xor_csum",  n_csum - s1, 1);
    chk("t6_xor_nobeat", beats.size() - b0, 0);
    chk("t6_xor_cnt",   32'(o_pkt_cnt), 6);
`endif

    // Reset mid-packet aborts silently
    s0 = n_csum + n_len + n_tmo + n_line + n_drop;
    send_byte(8'hA5, 1'b0); send_byte(8'h10, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    gap(3);
    chk("rst_mid_busy", 32'(o_busy), 0);
    chk("rst_mid_cnt",  32'(o_pkt_cnt), 0);
    chk("rst_mid_noerr", (n_csum + n_len + n_tmo + n_line + n_drop) - s0, 0);

    chk("one_err_per_cycle", multi_err, 0);
    chk("stall_stable",      stall_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
